// File: rtl/uart_tx_serializer.sv
// 8N1/8N2 UART transmitter, one frame in flight, LSB first, all outputs registered.
// Optional even-parity slot between data and stop bits: define UART_TX_PARITY_EN.
module uart_tx_serializer #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_byte,
  input  logic       transmit,
  output logic       is_transmitting,
  output logic       tx,
  output logic       tx_overrun
);

  localparam int unsigned   CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t          state;
  logic [CW-1:0]   baud_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift_reg;
  logic            baud_tick;
`ifdef UART_TX_PARITY_EN
  logic            parity_bit;
`endif

  assign baud_tick = (baud_cnt == CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      baud_cnt        <= '0;
      bit_idx         <= '0;
      shift_reg       <= '0;
      is_transmitting <= 1'b0;
      tx              <= 1'b1;
      tx_overrun      <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit      <= 1'b0;
`endif
    end else begin
      // busy includes the stop-completion edge, so a request there is an overrun
      tx_overrun <= transmit & is_transmitting;

      if (state != S_IDLE)
        baud_cnt <= baud_tick ? '0 : baud_cnt + 1'b1;

      case (state)
        S_IDLE: begin
          tx <= 1'b1;
          if (transmit) begin
            shift_reg       <= tx_byte;
`ifdef UART_TX_PARITY_EN
            parity_bit      <= ^tx_byte;
`endif
            is_transmitting <= 1'b1;
            tx              <= 1'b0;
            baud_cnt        <= '0;
            bit_idx         <= '0;
            state           <= S_START;
          end
        end

        S_START: begin
          if (baud_tick) begin
            state   <= S_DATA;
            bit_idx <= '0;
            tx      <= shift_reg[0];
          end
        end

        S_DATA: begin
          if (baud_tick) begin
            shift_reg <= {1'b0, shift_reg[7:1]};
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
              state   <= S_PARITY;
              tx      <= parity_bit;
`else
              state   <= S_STOP;
              tx      <= 1'b1;
`endif
            end else begin
              // tx is registered, so present the bit the shift is about to expose
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift_reg[1];
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (baud_tick) begin
            state <= S_STOP;
            tx    <= 1'b1;
          end
        end
`endif

        S_STOP: begin
          if (baud_tick) begin
            if (bit_idx == STOP_LAST) begin
              state           <= S_IDLE;
              is_transmitting <= 1'b0;
              tx              <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end

        default: begin
          state           <= S_IDLE;
          is_transmitting <= 1'b0;
          tx              <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: one DUT with STOP_BITS=1, one with STOP_BITS=2.
module tb_uart_tx_serializer;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FR_A = (1 + 8 + P + 1) * CPB;
  localparam int FR_B = (1 + 8 + P + 2) * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       transmit = 1'b0;
  logic       sel = 1'b0;
  logic       transmit_a, transmit_b;
  logic       tx_a, busy_a, ovr_a;
  logic       tx_b, busy_b, ovr_b;
  logic       tx_m, busy_m, ovr_m;

  int checks = 0;
  int errors = 0;

  assign transmit_a = transmit & ~sel;
  assign transmit_b = transmit & sel;
  assign tx_m   = sel ? tx_b   : tx_a;
  assign busy_m = sel ? busy_b : busy_a;
  assign ovr_m  = sel ? ovr_b  : ovr_a;

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .tx_byte(tx_byte), .transmit(transmit_a),
    .is_transmitting(busy_a), .tx(tx_a), .tx_overrun(ovr_a)
  );

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .tx_byte(tx_byte), .transmit(transmit_b),
    .is_transmitting(busy_b), .tx(tx_b), .tx_overrun(ovr_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Pulses transmit, then samples every cycle at negedge until busy drops (bounded).
  // slots[k] = tx in the middle of bit period k; ovr_cyc injects a second request mid-frame.
  task automatic send_frame(input logic [7:0] b, input bit no_gap, input int ovr_cyc,
                            input logic [7:0] ovr_byte, output logic [15:0] slots,
                            output int busy_cnt, output int ovr_cnt,
                            output logic ovr_after, output logic tx_after);
    int cyc;
    if (!no_gap) @(negedge clk);
    tx_byte  = b;
    transmit = 1'b1;
    @(negedge clk);
    transmit = 1'b0;
    check("accept_busy", 32'(busy_m), 32'd1);
    check("accept_tx", 32'(tx_m), 32'd0);
    slots = '0; busy_cnt = 0; ovr_cnt = 0; cyc = 0;
    while (busy_m === 1'b1 && cyc < 200) begin
      if (cyc % CPB == 2) slots[cyc / CPB] = tx_m;
      busy_cnt++;
      if (ovr_m === 1'b1) ovr_cnt++;
      if (cyc == ovr_cyc) begin
        tx_byte  = ovr_byte;
        transmit = 1'b1;
      end else if (cyc == ovr_cyc + 1) begin
        transmit = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    transmit  = 1'b0;
    ovr_after = ovr_m;
    tx_after  = tx_m;
  endtask

  function automatic logic [7:0] decode(input logic [15:0] s);
    logic [7:0] d;
    for (int i = 0; i < 8; i++) d[i] = s[1 + i];
    return d;
  endfunction

  task automatic idle_window(input string tag);
    int busy_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy_m !== 1'b0) busy_seen++;
    end
    check(tag, 32'(busy_seen), 32'd0);
  endtask

  logic [15:0] slots;
  int          busy_cnt, ovr_cnt;
  logic        ovr_after, tx_after;
  logic [7:0]  seq [3];

  initial begin
    seq[0] = 8'h55; seq[1] = 8'h12; seq[2] = 8'hAA;

    #1 rst = 1'b1;
    #20;
    check("rst_tx_a", 32'(tx_a), 32'd1);
    check("rst_busy_a", 32'(busy_a), 32'd0);
    check("rst_ovr_a", 32'(ovr_a), 32'd0);
    check("rst_tx_b", 32'(tx_b), 32'd1);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    check("idle_tx_a", 32'(tx_a), 32'd1);

    // 0x55, single pulse
    sel = 1'b0;
    send_frame(8'h55, 1'b0, -1, 8'h00, slots, busy_cnt, ovr_cnt, ovr_after, tx_after);
    check("b55_busy", 32'(busy_cnt), 32'(FR_A));
`ifdef UART_TX_PARITY_EN
    check("b55_slots", 32'(slots[10:0]), 32'h4AA);
`else
    check("b55_slots", 32'(slots[9:0]), 32'h2AA);
`endif
    check("b55_ovr", 32'(ovr_cnt), 32'd0);
    check("b55_idle", 32'(tx_after), 32'd1);

    // handshake loop: request on the first idle cycle
    for (int k = 0; k < 3; k++) begin
      send_frame(seq[k], 1'b1, -1, 8'h00, slots, busy_cnt, ovr_cnt, ovr_after, tx_after);
      check("hs_data", 32'(decode(slots)), 32'(seq[k]));
      check("hs_busy", 32'(busy_cnt), 32'(FR_A));
      check("hs_ovr", 32'(ovr_cnt + 32'(ovr_after)), 32'd0);
      check("hs_idle", 32'(tx_after), 32'd1);
    end

    // overrun at cycle 10 of a 0x00 frame
    send_frame(8'h00, 1'b0, 10, 8'hFF, slots, busy_cnt, ovr_cnt, ovr_after, tx_after);
    check("ovr_data", 32'(decode(slots)), 32'h00);
    check("ovr_start", 32'(slots[0]), 32'd0);
    check("ovr_pulses", 32'(ovr_cnt), 32'd1);
    check("ovr_busy", 32'(busy_cnt), 32'(FR_A));
    idle_window("ovr_not_sent");

    // request coinciding with stop-bit completion is an overrun
    send_frame(8'h3C, 1'b0, FR_A - 1, 8'hFF, slots, busy_cnt, ovr_cnt, ovr_after, tx_after);
    check("edge_data", 32'(decode(slots)), 32'h3C);
    check("edge_ovr", 32'(ovr_after), 32'd1);
    idle_window("edge_ignored");

    // parity slot (stop bit when parity is disabled)
    send_frame(8'h07, 1'b0, -1, 8'h00, slots, busy_cnt, ovr_cnt, ovr_after, tx_after);
    check("b07_data", 32'(decode(slots)), 32'h07);
    check("b07_slot9", 32'(slots[9]), 32'd1);
    send_frame(8'h55, 1'b0, -1, 8'h00, slots, busy_cnt, ovr_cnt, ovr_after, tx_after);
    check("b55_slot9", 32'(slots[9]), 32'(P ? 0 : 1));
    check("b55_busy2", 32'(busy_cnt), 32'(FR_A));

    // two stop bits
    sel = 1'b1;
    send_frame(8'hAA, 1'b0, -1, 8'h00, slots, busy_cnt, ovr_cnt, ovr_after, tx_after);
    check("s2_data", 32'(decode(slots)), 32'hAA);
    check("s2_busy", 32'(busy_cnt), 32'(FR_B));
    check("s2_stop0", 32'(slots[9 + P]), 32'd1);
    check("s2_stop1", 32'(slots[10 + P]), 32'd1);
    check("s2_idle", 32'(tx_after), 32'd1);

    // asynchronous reset during data bit 3 of 0x55
    sel = 1'b0;
    @(negedge clk);
    tx_byte = 8'h55; transmit = 1'b1;
    @(negedge clk);
    transmit = 1'b0;
    repeat (17) @(negedge clk);
    check("mid_tx_before", 32'(tx_a), 32'd0);
    check("mid_busy_before", 32'(busy_a), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_tx", 32'(tx_a), 32'd1);
    check("mid_rst_busy", 32'(busy_a), 32'd0);
    @(negedge clk) rst = 1'b0;
    idle_window("mid_rst_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Serial transmitter directly downstream of the debug-mode packet sender.
- Consumes one byte per `transmit` pulse and returns the `is_transmitting` busy flag.
- Shifts each byte out LSB-first as an 8N1 (or 8N2) UART frame on `tx` toward the PC.
- Sole physical output path of the debug link; single clock domain, no FIFO (one-frame capacity).

Parameters:
- CLKS_PER_BIT, 434: clk cycles per UART bit period; legal range 2..65535.
- STOP_BITS, 1: number of stop bits per frame; legal values 1 or 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- tx_byte  input  8  byte to send; sampled only on the edge where an accept occurs.
- transmit  input  1  send request; may be a single-cycle pulse.
- is_transmitting  output  1  busy flag; high while a frame is in flight.
- tx  output  1  UART serial line; idle high.
- tx_overrun  output  1  one-cycle pulse when `transmit` arrives while busy.

Behaviour:
- Reset (asynchronous, any state):
  - `tx`=1, `is_transmitting`=0, `tx_overrun`=0.
  - FSM returns to IDLE; baud counter, bit counter and shift register cleared.
  - A partially sent frame is abandoned; `tx` returns high immediately.
- FSM states: IDLE, START, DATA, PARITY (only with the optional feature), STOP.
- IDLE:
  - `tx`=1.
  - On an edge with `transmit`=1: load `tx_byte` into the shift register, set `is_transmitting`=1, enter START, clear the baud counter.
  - Acceptance latency: `is_transmitting` is high in the cycle after `transmit` is sampled, and `tx` drops to 0 in that same cycle.
- START: `tx`=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
- DATA:
  - `tx`=shift[0] for CLKS_PER_BIT cycles, then shift right and increment the bit index.
  - After bit 7: go to PARITY if enabled, else STOP.
- STOP:
  - `tx`=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - Then IDLE, with `is_transmitting` cleared on the same edge.
- Busy duration:
  - `is_transmitting` is high for exactly (1+8+P+STOP_BITS)*CLKS_PER_BIT consecutive cycles per frame; P=1 with parity, else 0.
- Back-to-back frames:
  - A `transmit` sampled on the first cycle `is_transmitting`=0 is accepted.
  - The next start bit begins one cycle later, so there is a minimum of 1 idle-high cycle between frames.
- Overrun:
  - A `transmit` sampled while `is_transmitting`=1 is ignored; the in-flight frame and the shift register are unaffected.
  - `tx_overrun` pulses high for 1 cycle, on the cycle after the sample.
- Simultaneous stop-bit completion and `transmit` on the same edge: counts as busy, so it is an overrun and is ignored.
- `transmit` held high continuously: one byte is accepted per idle window; while high, `tx_overrun` pulses once for every cycle spent busy.
- Baud counter:
  - Width $clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1, then wraps to 0 and advances the bit.
  - No fractional-baud correction.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state inserted between DATA and STOP.
  - `tx` = even parity, i.e. the XOR of the 8 data bits, for CLKS_PER_BIT cycles.
  - Frame length becomes 10+STOP_BITS bit periods.
- Undefined: no PARITY state, no parity logic synthesized, frame is 9+STOP_BITS bit periods.

Test Plan (CLKS_PER_BIT=4, STOP_BITS=1 unless noted):
- Reset idle → `tx`=1, `is_transmitting`=0, `tx_overrun`=0; asserting `rst` mid-frame (during data bit 3) → `tx`=1 and `is_transmitting`=0 with no clock edge required.
- Byte 0x55 (no parity):
  - `transmit` 1-cycle pulse → `is_transmitting` high next cycle for exactly 40 cycles.
  - `tx` per 4-cycle slot = 0,1,0,1,0,1,0,1,0,1.
- Packet-sender handshake loop:
  - Bytes 0x55, 0x12, 0xAA sent via pulse-on-idle → three frames decoded in order.
  - Each frame preceded by ≥1 idle-high cycle; no `tx_overrun`.
- Overrun: `transmit` with 0xFF at cycle 10 of a 0x00 frame → frame bits remain all 0, `tx_overrun` pulses once, 0xFF is never sent.
- STOP_BITS=2, byte 0xAA → `tx` high for 8 cycles after the last data bit; `is_transmitting` high for 44 cycles total.
- UART_TX_PARITY_EN defined:
  - Byte 0x07 → parity slot `tx`=1; byte 0x55 → parity slot `tx`=0.
  - `is_transmitting` high for 44 cycles per frame.
